cc_puncture: RTL and testbench

Puncturing stage directly downstream of the 1/2-rate convolutional coder. It accepts mother-code bit pairs (X, Y) and discards bits according to the 802.16 OFDM puncture pattern for the selected code rate (1/2, 2/3, 3/4, 5/6). It serializes the surviving bits one per clock into a small tagged FIFO that feeds the bit interleaver. It exerts backpressure on the coder because rate 1/2 produces two bits per pair against one output bit per clock.

---
 rtl/cc_pkg.sv | 36 +++
 rtl/cc_puncture_if.sv | 23 ++
 rtl/punc_fifo.sv | 56 +++++
 rtl/cc_puncture.sv | 100 ++++++++++
 tb/tb_cc_puncture.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
// Rate codes, puncture period and keep-mask lookup shared by the coder wrapper and puncturer.
package cc_pkg;

  localparam int unsigned CC_RATE_W = 2;

  typedef enum logic [CC_RATE_W-1:0] {
    CC_RATE_1_2 = 2'd0,
    CC_RATE_2_3 = 2'd1,
    CC_RATE_3_4 = 2'd2,
    CC_RATE_5_6 = 2'd3
  } cc_rate_e;

  function automatic logic [2:0] cc_period(cc_rate_e rate);
    logic [2:0] p;
    p = 3'd1;
    case (rate)
      CC_RATE_1_2: p = 3'd1;
      CC_RATE_2_3: p = 3'd2;
      CC_RATE_3_4: p = 3'd3;
      CC_RATE_5_6: p = 3'd5;
      default:     p = 3'd1;
    endcase
    return p;
  endfunction

  // Returns {keep_Y, keep_X}. All 802.16 patterns share the prefix 11,10,01,10,01,
  // so phase alone selects the mask; out-of-period phases fall back to keep-both.
  function automatic logic [1:0] cc_keep(cc_rate_e rate, logic [2:0] ph);
    logic [1:0] m;
    if (ph == 3'd0 || ph >= cc_period(rate)) m = 2'b11;
    else if (ph[0])                          m = 2'b10;
    else                                     m = 2'b01;
    return m;
  endfunction

endpackage

// File: rtl/cc_puncture_if.sv
// Coder-to-puncturer pair stream and puncturer-to-interleaver bit stream.
interface cc_puncture_if;
  logic       valid_in;
  logic [1:0] xy_in;
  logic       sob_in;
  logic       eob_in;
  logic [1:0] cc_rate;
  logic       in_ready;
  logic       z;
  logic       valid_out;
  logic       last_out;
  logic       phase_err;

  modport master (
    output valid_in, xy_in, sob_in, eob_in, cc_rate,
    input  in_ready, z, valid_out, last_out, phase_err
  );

  modport slave (
    input  valid_in, xy_in, sob_in, eob_in, cc_rate,
    output in_ready, z, valid_out, last_out, phase_err
  );
endinterface

// File: rtl/punc_fifo.sv
// Tagged bit FIFO: up to two writes and one read per clock, registered read port.
module punc_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr0_en,
  input  logic [1:0]  i_wr0,
  input  logic        i_wr1_en,
  input  logic [1:0]  i_wr1,
  output logic [AW:0] o_count,
  output logic        o_rd_valid,
  output logic [1:0]  o_rd
);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_rd_valid;
  logic [1:0]    r_rd;
  logic          w_rd;
  logic [AW-1:0] w_wptr1;

  assign w_rd    = (r_count != '0);
  assign w_wptr1 = r_wptr + AW'(1);

  always_ff @(posedge clk) begin
    if (i_wr0_en) r_mem[r_wptr]  <= i_wr0;
    if (i_wr1_en) r_mem[w_wptr1] <= i_wr1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd       <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_wr0_en) + AW'(i_wr1_en);
      r_count <= r_count + (AW+1)'(i_wr0_en) + (AW+1)'(i_wr1_en) - (AW+1)'(w_rd);
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd   <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  assign o_count    = r_count;
  assign o_rd_valid = r_rd_valid;
  assign o_rd       = r_rd;

endmodule

// File: rtl/cc_puncture.sv
// 802.16 OFDM puncturer: rate latch, phase counter, mask steering into a tagged bit FIFO.
module cc_puncture
  import cc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [1:0] xy_in,
  input  logic       sob_in,
  input  logic       eob_in,
  input  logic [1:0] cc_rate,
  output logic       in_ready,
  output logic       z,
  output logic       valid_out,
  output logic       last_out,
  output logic       phase_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  cc_rate_e      r_rate;
  logic [2:0]    r_ph;
  logic          r_perr;

  cc_rate_e      w_rate;
  logic [2:0]    w_ph;
  logic [1:0]    w_keep;
  logic          w_last_ph;
  logic          w_accept;
  logic          w_wr0_en;
  logic          w_wr1_en;
  logic [1:0]    w_wr0;
  logic [1:0]    w_wr1;
  logic [CW-1:0] w_count;
  logic [1:0]    w_rd;

  // The sob pair uses its own cc_rate and phase 0 before the latch updates.
  assign w_rate    = sob_in ? cc_rate_e'(cc_rate) : r_rate;
  assign w_ph      = sob_in ? 3'd0 : r_ph;
  assign w_keep    = cc_keep(w_rate, w_ph);
  assign w_last_ph = (w_ph == cc_period(w_rate) - 3'd1);
  assign in_ready  = (DEPTH_C - w_count) >= CW'(2);
  assign w_accept  = valid_in && in_ready;

  // Kept bits are packed X-first; the tag lands on whichever entry is written last.
  always_comb begin
    w_wr0_en = 1'b0;
    w_wr1_en = 1'b0;
    w_wr0    = '0;
    w_wr1    = '0;
    if (w_accept) begin
      w_wr0_en = 1'b1;
      if (w_keep == 2'b11) begin
        w_wr1_en = 1'b1;
        w_wr0    = {1'b0, xy_in[0]};
        w_wr1    = {eob_in, xy_in[1]};
      end else if (w_keep[0]) begin
        w_wr0    = {eob_in, xy_in[0]};
      end else begin
        w_wr0    = {eob_in, xy_in[1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rate <= CC_RATE_1_2;
      r_ph   <= '0;
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_accept && eob_in && !w_last_ph;
      if (w_accept) begin
        if (sob_in) r_rate <= w_rate;
        r_ph <= (eob_in || w_last_ph) ? 3'd0 : w_ph + 3'd1;
      end
    end
  end

  punc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr0_en   (w_wr0_en),
    .i_wr0      (w_wr0),
    .i_wr1_en   (w_wr1_en),
    .i_wr1      (w_wr1),
    .o_count    (w_count),
    .o_rd_valid (valid_out),
    .o_rd       (w_rd)
  );

  assign z         = w_rd[0];
  assign last_out  = w_rd[1];
  assign phase_err = r_perr;

endmodule

// File: tb/tb_cc_puncture.sv
// Directed bench for cc_puncture with a {tag,bit} scoreboard fed by an independent puncture model.
module tb_cc_puncture;

  logic clk;
  logic rst;

  cc_puncture_if bus ();

  cc_puncture #(
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .valid_in  (bus.valid_in),
    .xy_in     (bus.xy_in),
    .sob_in    (bus.sob_in),
    .eob_in    (bus.eob_in),
    .cc_rate   (bus.cc_rate),
    .in_ready  (bus.in_ready),
    .z         (bus.z),
    .valid_out (bus.valid_out),
    .last_out  (bus.last_out),
    .phase_err (bus.phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [1:0] sb[$];
  logic       exp_perr = 1'b0;
  logic       stream_chk = 1'b0;
  logic       prev_valid = 1'b0;
  logic       ready_low_seen = 1'b0;
  logic       perr_seen = 1'b0;
  int unsigned m_rate = 0;
  int unsigned m_ph = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned tb_period(int unsigned r);
    case (r)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  // {keep_Y, keep_X} written out from the 802.16 tables
  function automatic logic [1:0] tb_mask(int unsigned r, int unsigned p);
    case (r)
      0: return 2'b11;
      1: return (p == 0) ? 2'b11 : 2'b10;
      2: case (p) 0: return 2'b11; 1: return 2'b10; default: return 2'b01; endcase
      default: case (p)
        0: return 2'b11; 1: return 2'b10; 2: return 2'b01; 3: return 2'b10; default: return 2'b01;
      endcase
    endcase
  endfunction

  task automatic model_accept(input logic x, y, sob, eob, input logic [1:0] rate);
    logic [1:0] m;
    int unsigned p;
    if (sob) begin
      m_rate = rate;
      m_ph   = 0;
    end
    p = tb_period(m_rate);
    m = tb_mask(m_rate, m_ph);
    if (m == 2'b11) begin
      sb.push_back({1'b0, x});
      sb.push_back({eob, y});
    end else if (m == 2'b01) begin
      sb.push_back({eob, x});
    end else begin
      sb.push_back({eob, y});
    end
    exp_perr = eob && (m_ph != p - 1);
    if (eob || m_ph == p - 1) m_ph = 0;
    else                      m_ph++;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic x, y, sob, eob, input logic [1:0] rate);
    int unsigned guard;
    guard = 0;
    bus.valid_in = 1'b1;
    bus.xy_in    = {y, x};
    bus.sob_in   = sob;
    bus.eob_in   = eob;
    bus.cc_rate  = rate;
    @(negedge clk);
    while (!bus.in_ready && guard < 64) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    model_accept(x, y, sob, eob, rate);
  endtask

  task automatic idle(input int unsigned n);
    bus.valid_in = 1'b0;
    bus.sob_in   = 1'b0;
    bus.eob_in   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("phase_err", {31'd0, bus.phase_err}, {31'd0, exp_perr});
      if (bus.phase_err) perr_seen = 1'b1;
      exp_perr = 1'b0;
      if (!bus.in_ready) ready_low_seen = 1'b1;
      if (stream_chk && prev_valid && sb.size() > 0)
        check("stream_gap", {31'd0, bus.valid_out}, 32'd1);
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'd0, bus.valid_out}, 32'd0);
        end else begin
          logic [1:0] e;
          e = sb.pop_front();
          check("z", {31'd0, bus.z}, {31'd0, e[0]});
          check("last_out", {31'd0, bus.last_out}, {31'd0, e[1]});
        end
      end
      prev_valid = bus.valid_out;
    end
  end

  logic [1:0] d56 [10] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01};

  initial begin
    int unsigned guard;
    rst = 1'b1;
    bus.valid_in = 1'b1;
    bus.xy_in    = 2'b11;
    bus.sob_in   = 1'b1;
    bus.eob_in   = 1'b0;
    bus.cc_rate  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("rst_z", {31'd0, bus.z}, 32'd0);
    check("rst_last_out", {31'd0, bus.last_out}, 32'd0);
    check("rst_phase_err", {31'd0, bus.phase_err}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.valid_in = 1'b0;
    rst = 1'b0;
    idle(3);

    // rate 3/4 short block: z = 1,0,1,1
    send(1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    send(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    send(1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
    idle(8);

    // rate 5/6, ten back-to-back pairs
    for (int i = 0; i < 10; i++)
      send(d56[i][0], d56[i][1], i == 0, i == 9, 2'd3);
    idle(10);

    // rate 1/2 stream, 16 pairs: no gaps, in_ready must throttle
    ready_low_seen = 1'b0;
    stream_chk = 1'b1;
    for (int i = 0; i < 16; i++)
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 0, i == 15, 2'd0);
    idle(20);
    stream_chk = 1'b0;
    check("ready_throttled_1_2", {31'd0, ready_low_seen}, 32'd1);

    // rate 2/3 short block ending at phase 0
    perr_seen = 1'b0;
    send(1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    send(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    send(1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    idle(8);
    check("perr_2_3_seen", {31'd0, perr_seen}, 32'd1);

    // rate change mid-block is ignored until the next sob
    send(1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
    send(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    send(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    send(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    send(1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    idle(8);

    // single-pair blocks: error unless period is 1
    send(1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
    idle(4);
    send(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    idle(4);

    // reset with data buffered
    for (int i = 0; i < 5; i++)
      send(1'b1, 1'b1, i == 0, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    check("midrst_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb.delete();
    exp_perr = 1'b0;
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send(1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
    send(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    send(1'b1, 1'b0, 1'b0, 1'b1, 2'd2);

    guard = 0;
    bus.valid_in = 1'b0;
    while (sb.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    idle(3);
    check("drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
